// File: rtl/lsu_dm_master.sv
// lsu_dm_master
// Load/store unit master for a single-ported data memory. One request at a
// time is accepted from the pipeline. Each request becomes a load, a word
// store, a read-modify-write sub-word store, or a misalignment error, and
// finishes with a single-cycle completion pulse on resp_valid.
//
// Ports
//   clk, rstn            clock; asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_we, req_size,    store flag, access size (00 B, 01 H, 10 W, 11 rsvd),
//   req_unsigned         load zero-extend flag
//   req_addr, req_wdata  byte address, right-aligned store data
//   req_pc               pc of the issuing instruction
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores and errors)
//   resp_misalign        error flag, valid with resp_valid
//   DMWr, addr, din      memory write enable (memory writes on falling edge),
//                        word address, full-word write data
//   dout                 combinational memory read data for addr
//   pc                   latched req_pc for memory trace
module lsu_dm_master (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        DMWr,
  output logic [31:0] addr,
  output logic [31:0] din,
  input  logic [31:0] dout,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    STORE  = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        accept_s;
  logic        req_misalign_s;

  logic        we_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] pc_r;
  logic [31:0] din_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_misalign_r;

  // Misalignment: half needs even address, word needs 4-byte alignment,
  // size 11 is reserved and always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Select the addressed byte/half lane from a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the low byte/half of the store data onto the addressed lane;
  // the remaining lanes keep the value read from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   r[7:0]   = wdata[7:0];
          2'b01:   r[15:8]  = wdata[7:0];
          2'b10:   r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        r = off[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign req_misalign_s = is_misaligned(req_size, req_addr[1:0]);

  // Next-state selection and request acceptance.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (req_misalign_s) begin
            state_s = ERR;
          end else if (!req_we) begin
            state_s = LOAD;
          end else if (req_size == 2'b10) begin
            state_s = STORE;
          end else begin
            state_s = RMW_RD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RMW_RD:  state_s = STORE;
      LOAD:    state_s = IDLE;
      STORE:   state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch: the transaction works from this copy, not from req_*.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_r       <= 1'b0;
      size_r     <= 2'b00;
      unsigned_r <= 1'b0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      pc_r       <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r       <= req_we;
      size_r     <= req_size;
      unsigned_r <= req_unsigned;
      addr_r     <= req_addr;
      wdata_r    <= req_wdata;
      pc_r       <= req_pc;
    end
  end

  // Write data: full word straight from the request, or the merged word
  // captured from memory at the end of the read phase of a sub-word store.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_r <= 32'h0000_0000;
    end else if (accept_s && req_we && (req_size == 2'b10) && !req_misalign_s) begin
      din_r <= req_wdata;
    end else if (state_r == RMW_RD) begin
      din_r <= store_merge(dout, wdata_r, size_r, addr_r[1:0]);
    end
  end

  // Completion: a pulse on the edge that leaves LOAD, STORE or ERR. The we_r
  // qualifier keeps store/error responses at zero data even if corrupted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_valid_r    <= 1'b0;
      resp_rdata_r    <= 32'h0000_0000;
      resp_misalign_r <= 1'b0;
    end else begin
      resp_valid_r    <= (state_r == LOAD) || (state_r == STORE) || (state_r == ERR);
      resp_rdata_r    <= ((state_r == LOAD) && !we_r) ?
                         load_extract(dout, size_r, addr_r[1:0], unsigned_r) : 32'h0000_0000;
      resp_misalign_r <= (state_r == ERR);
    end
  end

  // Decodes of the state register: an async reset forces IDLE, so DMWr
  // drops immediately and no falling-edge write can follow.
  assign req_ready     = (state_r == IDLE);
  assign DMWr          = (state_r == STORE);
  assign addr          = ((state_r == LOAD) || (state_r == RMW_RD) || (state_r == STORE)) ?
                         {addr_r[31:2], 2'b00} : 32'h0000_0000;
  assign din           = din_r;
  assign pc            = pc_r;
  assign resp_valid    = resp_valid_r;
  assign resp_rdata    = resp_rdata_r;
  assign resp_misalign = resp_misalign_r;

endmodule

// File: tb/tb_lsu_dm_master.sv
module tb_lsu_dm_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        DMWr;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] pc;

  lsu_dm_master dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .DMWr(DMWr), .addr(addr), .din(din), .dout(dout), .pc(pc)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] rdata; logic mis; int unsigned at_edge; } resp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; int unsigned at_edge; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  // Reference memory as a flat byte array.
  logic [7:0] refm [0:255];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ref_word(input int wa);
    return {refm[wa+3], refm[wa+2], refm[wa+1], refm[wa]};
  endfunction

  // Memory model: combinational read, falling-edge write, write checker.
  logic [31:0] mem [0:63];
  assign dout = mem[addr[7:2]];

  initial begin
    wr_t w;
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (DMWr) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", {31'b0, DMWr}, 32'h0);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", addr, w.a);
          chk("wr_data", din, w.d);
          chk("wr_cycle", cyc, w.at_edge);
        end
        mem[addr[7:2]] = din;
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_resp", {31'b0, resp_valid}, 32'h0);
        end else begin
          r = rq.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_misalign", {31'b0, resp_misalign}, {31'b0, r.mis});
          chk("resp_cycle", cyc, r.at_edge);
        end
      end
    end
  end

  // Issue one request; if track, compute the expected outcome from the
  // byte-array model and queue it for the monitors.
  task automatic issue(input logic we, input logic [1:0] s, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit track);
    logic [31:0] p;
    logic [31:0] rnd;
    logic [63:0] v;
    int unsigned acc;
    int nb;
    int n;
    int budget;
    int wa;
    resp_t r;
    wr_t w;
    p = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = s; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_pc = p;
    budget = 0;
    while (!req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      chk("ready_timeout", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    // Scramble the request bus; the DUT must work from its latched copy.
    rnd = $urandom;
    req_valid = 1'b0; req_we = rnd[0]; req_size = rnd[2:1]; req_unsigned = rnd[3];
    req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
    chk("pc_latch", pc, p);
    if (!track) return;
    nb = 1 << s;
    if (s == 2'd3 || (a % nb) != 0) begin
      r.rdata = 32'h0; r.mis = 1'b1; r.at_edge = acc + 1;
      rq.push_back(r);
    end else if (!we) begin
      v = 64'h0;
      for (int i = 0; i < nb; i++) v = v | (64'(refm[int'(a) + i]) << (8 * i));
      if (!uns && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
      r.rdata = v[31:0]; r.mis = 1'b0; r.at_edge = acc + 1;
      rq.push_back(r);
    end else begin
      for (int i = 0; i < nb; i++) refm[int'(a) + i] = 8'(wd >> (8 * i));
      wa = int'(a) & ~3;
      n = (nb == 4) ? 2 : 3;
      w.a = 32'(wa); w.d = ref_word(wa); w.at_edge = acc + 32'(n) - 2;
      wq.push_back(w);
      r.rdata = 32'h0; r.mis = 1'b0; r.at_edge = acc + 32'(n) - 1;
      rq.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_DMWr"}, {31'b0, DMWr}, 32'h0);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'h0);
    chk({tag, "_resp_misalign"}, {31'b0, resp_misalign}, 32'h0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_din"}, din, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
  endtask

  initial begin
    logic [31:0] rnd;
    int unsigned rcnt;
    for (int i = 0; i < 64; i++) begin
      {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]} = init_word(i);
    end

    // Power-on reset.
    idle(3);
    chk_reset_outputs("por");
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("por_ready", {31'b0, req_ready}, 32'h1);

    // Word store then word load.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    idle(3);

    // Sub-word read-modify-write and byte loads.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AB, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b1);

    // Half loads, signed.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8001_7FFF, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b1);

    // Misaligned and reserved size.
    issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h16, 32'hCAFE_F00D, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 32'h14, 32'h1234_5678, 1'b1);
    idle(4);

    // Reset pulsed in the STORE cycle, before the falling edge.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h0000_0055, 1'b0);
    #1 rstn = 1'b0;
    #1;
    chk("rst_DMWr_drop", {31'b0, DMWr}, 32'h0);
    idle(2);
    chk_reset_outputs("midrst");
    chk("midrst_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", {31'b0, req_ready}, 32'h1);
    chk("midrst_mem_unchanged", mem[8], ref_word(32'h20));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_resp", {31'b0, resp_valid}, 32'h0);
    end

    // Randomized traffic, back-to-back with occasional gaps.
    for (int k = 0; k < 300; k++) begin
      rnd = $urandom;
      issue(rnd[0], rnd[2:1], rnd[3], 32'($urandom_range(0, 255)), $urandom, 1'b1);
      rcnt = $urandom_range(0, 3);
      if (rcnt == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(6);
    chk("resp_queue_drained", 32'(rq.size()), 32'h0);
    chk("write_queue_drained", 32'(wq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_dm_master.md
LSU_DM_MASTER -- requirements
Module: lsu_dm_master

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk rises and falls once per cycle; rstn low forces reset immediately, regardless of clk.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline access request.
- req_ready  out  1  request accepted when req_valid & req_ready at rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extend (1) or sign-extend (0).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_pc  in  32  pc of the issuing instruction.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_misalign  out  1  error flag, valid with resp_valid.
- DMWr  out  1  memory write enable; memory writes on falling edge.
- addr  out  32  word address to memory.
- din  out  32  full-word write data to memory.
- dout  in  32  combinational memory read data for addr.
- pc  out  32  latched req_pc, for memory trace.

Function
REQ-003 SHALL implement states IDLE, LOAD, RMW_RD, STORE, ERR; req_ready = (state == IDLE).
REQ-004 On acceptance SHALL latch we, size, unsigned, addr, wdata, pc.
REQ-005 Misalignment is:
- size 01 with addr[0]=1
- size 10 with addr[1:0]!=0
- size 11
Misaligned request -> ERR; no memory access; DMWr stays 0.
REQ-006 SHALL choose the next state on acceptance as:
- aligned load -> LOAD
- aligned word store -> STORE
- aligned byte/half store -> RMW_RD
REQ-007 SHALL drive addr = {latched_addr[31:2], 2'b00} in LOAD, RMW_RD and STORE; otherwise addr = 0.
REQ-008 LOAD: at the rising edge ending LOAD, SHALL select the lane from dout and extend it:
- byte lane k = dout[8k+7:8k], k = addr[1:0]
- half = dout[31:16] if addr[1], else dout[15:0]
- sign-extend if unsigned=0, else zero-extend
Then register resp_rdata, pulse resp_valid, and go to IDLE.
REQ-009 RMW_RD: at its ending edge SHALL capture dout, merge wdata's low byte/half into the addressed lane (other lanes unchanged) into din, and go to STORE.
REQ-010 Word store SHALL set din = wdata at acceptance.
REQ-011 STORE: DMWr = 1 for exactly this one cycle (decoded from the state register); at its ending edge SHALL pulse resp_valid with resp_rdata = 0 and go to IDLE.
REQ-012 ERR: at its ending edge SHALL pulse resp_valid with resp_misalign = 1, resp_rdata = 0, and go to IDLE.
REQ-013 Latency, counted from the acceptance edge k, with resp_valid high in cycle k+n:
- load: n = 2
- word store: n = 2
- sub-word store: n = 3
- error: n = 2
REQ-014 resp_valid SHALL be high for exactly one cycle per accepted request; resp_misalign = 0 on non-error responses.
REQ-015 A new request SHALL be acceptable in the same cycle resp_valid is high (IDLE entered), giving back-to-back throughput.
REQ-016 req_* inputs SHALL be ignored while req_ready = 0; the latched copy is used throughout the transaction.
REQ-017 pc output SHALL hold the latched req_pc from acceptance until the next acceptance.

Reset
REQ-018 rstn low SHALL immediately set state = IDLE and force to 0:
- DMWr, resp_valid, resp_misalign
- resp_rdata, addr, din, pc
REQ-019 Reset asserted mid-transaction (including during STORE before the falling edge) SHALL abort it: DMWr drops asynchronously, no memory write, and no resp_valid after release.
REQ-020 After rstn rises, SHALL reach req_ready = 1 in the first cycle.

Verification
REQ-021 Bench SHALL cover:
- Word store 0xDEADBEEF to 0x10, then word load 0x10 -> DMWr high one cycle with addr 0x10; load resp_rdata = 0xDEADBEEF at acceptance+2.
- Memory[0x10] = 0x11223344; byte store 0xAB to 0x12 -> din = 0x11AB3344 at acceptance+2 and resp at +3; then signed byte load from 0x12 -> 0xFFFFFFAB; unsigned byte load -> 0x000000AB.
- Signed half load from 0x12 with word 0x8001_7FFF -> 0xFFFF8001; from 0x10 -> 0x00007FFF.
- Half load at 0x11, word store at 0x16, size 11 -> resp_misalign = 1 at acceptance+2, resp_rdata = 0, DMWr never asserted.
- Reset pulsed during STORE of 0x55 to 0x20 -> memory[0x20] unchanged, no resp_valid, req_ready = 1 after release.
- Back-to-back: load issued in the resp_valid cycle of a prior store -> accepted at that edge; each response is a single-cycle pulse.
